simmem_delay_calculator: RTL and testbench

Timing stage directly upstream of the simulated memory controller's response banks. Accepts address requests, assigns each a simulated DRAM latency (row-hit or row-miss cost), counts it down in a slot table, and emits one release (transaction ID) per cycle when a latency expires. Releases are the source for the bank release-enable logic. Same-ID releases always leave in acceptance order (AXI ordering).

---
 rtl/simmem_pkg.sv | 25 ++
 rtl/simmem_prio_encoder.sv | 35 +++
 rtl/simmem_delay_calculator.sv | 170 +++++++++++++++++
 tb/tb_simmem_delay_calculator.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// -----------------------------------------------------------------------------
// simmem_pkg
// Shared types and default constants for the simulated-memory delay calculator.
//   - Default geometry and DRAM latency costs (row hit / row miss).
//   - slot_t: one slot-table entry at the default geometry (valid, id,
//     counter, older mask). The top module builds the same layout at its own
//     parameter widths.
// Optional feature macro: SIMMEM_ROW_HIT_EN (see simmem_delay_calculator).
// -----------------------------------------------------------------------------
package simmem_pkg;

    localparam int unsigned DefaultNumSlots     = 8;
    localparam int unsigned DefaultIdWidth      = 4;
    localparam int unsigned DefaultCounterWidth = 8;
    localparam int unsigned DefaultRowHitCost   = 2;
    localparam int unsigned DefaultRowMissCost  = 10;

    typedef struct packed {
        logic                           valid;
        logic [DefaultIdWidth-1:0]      id;
        logic [DefaultCounterWidth-1:0] counter;
        logic [DefaultNumSlots-1:0]     older;
    } slot_t;

endpackage

// File: rtl/simmem_prio_encoder.sv
// -----------------------------------------------------------------------------
// simmem_prio_encoder
// Lowest-set-bit finder.
//   req_i    in  Width          request vector
//   onehot_o out Width          one-hot of the lowest set bit ('0 if none)
//   idx_o    out $clog2(Width)  index of the lowest set bit (0 if none)
//   any_o    out 1              at least one bit of req_i is set
// -----------------------------------------------------------------------------
module simmem_prio_encoder #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0]         req_i,
    output logic [Width-1:0]         onehot_o,
    output logic [$clog2(Width)-1:0] idx_o,
    output logic                     any_o
);

    localparam int unsigned IdxWidth = $clog2(Width);

    always_comb begin
        logic found;
        found    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            if (req_i[i] && !found) begin
                found       = 1'b1;
                onehot_o[i] = 1'b1;
                idx_o       = IdxWidth'(i);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/simmem_delay_calculator.sv
// -----------------------------------------------------------------------------
// simmem_delay_calculator
// Assigns each accepted request a simulated DRAM latency, counts it down in a
// slot table and releases one transaction ID per cycle once its latency has
// expired. Same-ID transactions release in acceptance order.
//   clk_i            in  1          clock, rising edge
//   rst_i            in  1          synchronous active-high reset
//   addr_valid_i     in  1          request valid
//   addr_ready_o     out 1          a free slot exists
//   addr_i           in  AddrWidth  request address
//   id_i             in  IDWidth    request ID
//   release_valid_o  out 1          an expired, order-eligible slot exists
//   release_ready_i  in  1          consumer takes the release
//   release_id_o     out IDWidth    released transaction ID (0 when none)
// Macro SIMMEM_ROW_HIT_EN: when defined, an open-row tracker charges
// RowHitCost on a row hit; otherwise every request costs RowMissCost.
// -----------------------------------------------------------------------------
module simmem_delay_calculator
    import simmem_pkg::*;
#(
    parameter int unsigned NumSlots     = DefaultNumSlots,
    parameter int unsigned IDWidth      = DefaultIdWidth,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned CounterWidth = DefaultCounterWidth,
    parameter int unsigned RowLsb       = 10,
    parameter int unsigned RowHitCost   = DefaultRowHitCost,
    parameter int unsigned RowMissCost  = DefaultRowMissCost
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 addr_valid_i,
    output logic                 addr_ready_o,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [IDWidth-1:0]   id_i,
    output logic                 release_valid_o,
    input  logic                 release_ready_i,
    output logic [IDWidth-1:0]   release_id_o
);

    localparam int unsigned IdxWidth = $clog2(NumSlots);
    localparam logic [CounterWidth-1:0] MissDelay = CounterWidth'(RowMissCost);

    typedef struct packed {
        logic                    valid;
        logic [IDWidth-1:0]      id;
        logic [CounterWidth-1:0] counter;
        logic [NumSlots-1:0]     older;
    } slot_entry_t;

    slot_entry_t slots_q [NumSlots];
    slot_entry_t slots_d [NumSlots];

    logic [NumSlots-1:0] free_vec;
    logic [NumSlots-1:0] eligible_vec;
    logic [NumSlots-1:0] same_id_vec;
    logic [NumSlots-1:0] free_onehot;
    logic [NumSlots-1:0] rel_onehot;
    logic [NumSlots-1:0] rel_clear;
    logic [IdxWidth-1:0] unused_free_idx;
    logic [IdxWidth-1:0] rel_idx;
    logic                free_any;
    logic                rel_any;
    logic                accept;
    logic                release_fire;
    logic [CounterWidth-1:0] delay;

    always_comb begin
        free_vec     = '0;
        eligible_vec = '0;
        same_id_vec  = '0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            free_vec[i]     = !slots_q[i].valid;
            eligible_vec[i] = slots_q[i].valid && (slots_q[i].counter == '0)
                              && (slots_q[i].older == '0);
            same_id_vec[i]  = slots_q[i].valid && (slots_q[i].id == id_i);
        end
    end

    simmem_prio_encoder #(.Width(NumSlots)) u_free_sel (
        .req_i    (free_vec),
        .onehot_o (free_onehot),
        .idx_o    (unused_free_idx),
        .any_o    (free_any)
    );

    simmem_prio_encoder #(.Width(NumSlots)) u_rel_sel (
        .req_i    (eligible_vec),
        .onehot_o (rel_onehot),
        .idx_o    (rel_idx),
        .any_o    (rel_any)
    );

    // Outputs are forced low while reset is asserted, even if stale slots
    // are still held in the registers during that cycle.
    assign addr_ready_o    = free_any && !rst_i;
    assign release_valid_o = rel_any && !rst_i;
    assign release_id_o    = release_valid_o ? slots_q[rel_idx].id : '0;

    assign accept       = addr_valid_i && addr_ready_o;
    assign release_fire = release_valid_o && release_ready_i;
    assign rel_clear    = release_fire ? rel_onehot : '0;

`ifdef SIMMEM_ROW_HIT_EN
    localparam int unsigned RowWidth = AddrWidth - RowLsb;
    localparam logic [CounterWidth-1:0] HitDelay = CounterWidth'(RowHitCost);

    logic [RowWidth-1:0] open_row_q, open_row_d;
    logic                open_valid_q, open_valid_d;
    logic [RowWidth-1:0] req_row;

    assign req_row = addr_i[AddrWidth-1:RowLsb];
    assign delay   = (open_valid_q && (req_row == open_row_q)) ? HitDelay : MissDelay;

    always_comb begin
        open_row_d   = open_row_q;
        open_valid_d = open_valid_q;
        if (accept) begin
            open_row_d   = req_row;
            open_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            open_row_q   <= '0;
            open_valid_q <= 1'b0;
        end else begin
            open_row_q   <= open_row_d;
            open_valid_q <= open_valid_d;
        end
    end
`else
    logic unused_addr;
    assign unused_addr = ^addr_i;
    assign delay       = MissDelay;
`endif

    // Slot update order: decrement, then release clears, then accept
    // overwrites the target slot. A slot released this edge is not free to
    // the encoder yet, so accept never targets it in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < NumSlots; i++) begin
            slots_d[i] = slots_q[i];
            if (slots_q[i].valid && (slots_q[i].counter != '0)) begin
                slots_d[i].counter = slots_q[i].counter - 1'b1;
            end
            slots_d[i].older = slots_q[i].older & ~rel_clear;
            if (rel_clear[i]) begin
                slots_d[i].valid = 1'b0;
            end
            if (accept && free_onehot[i]) begin
                slots_d[i].valid   = 1'b1;
                slots_d[i].id      = id_i;
                slots_d[i].counter = delay;
                slots_d[i].older   = same_id_vec & ~rel_clear;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumSlots; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            slots_q <= slots_d;
        end
    end

endmodule

// File: tb/tb_simmem_delay_calculator.sv
// -----------------------------------------------------------------------------
// tb_simmem_delay_calculator
// Directed bench for simmem_delay_calculator with hand-computed release
// cycles. Expectations follow SIMMEM_ROW_HIT_EN as compiled.
// -----------------------------------------------------------------------------
module tb_simmem_delay_calculator;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        addr_valid_i;
    logic        addr_ready_o;
    logic [31:0] addr_i;
    logic [3:0]  id_i;
    logic        release_valid_o;
    logic        release_ready_i;
    logic [3:0]  release_id_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ev_id[$];
    int ev_cyc[$];

    always #5 clk_i = ~clk_i;

    simmem_delay_calculator dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .addr_valid_i    (addr_valid_i),
        .addr_ready_o    (addr_ready_o),
        .addr_i          (addr_i),
        .id_i            (id_i),
        .release_valid_o (release_valid_o),
        .release_ready_i (release_ready_i),
        .release_id_o    (release_id_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_i           = 1'b1;
        addr_valid_i    = 1'b0;
        release_ready_i = 1'b1;
        addr_i          = '0;
        id_i            = '0;
        step();
        check_eq("rst_addr_ready", 32'(addr_ready_o), 0);
        check_eq("rst_release_valid", 32'(release_valid_o), 0);
        check_eq("rst_release_id", 32'(release_id_o), 0);
        step();
        rst_i = 1'b0;
        #1;
        check_eq("post_rst_addr_ready", 32'(addr_ready_o), 1);
        check_eq("post_rst_release_valid", 32'(release_valid_o), 0);
        ev_id.delete();
        ev_cyc.delete();
    endtask

    task automatic send(input logic [31:0] a, input logic [3:0] id);
        check_eq("send_ready", 32'(addr_ready_o), 1);
        addr_i       = a;
        id_i         = id;
        addr_valid_i = 1'b1;
        step();
        addr_valid_i = 1'b0;
    endtask

    task automatic log_releases(input int n);
        for (int k = 0; k < n; k++) begin
            if (release_valid_o && release_ready_i) begin
                ev_id.push_back(int'(release_id_o));
                ev_cyc.push_back(cyc);
            end
            step();
        end
    endtask

    task automatic check_event(input string tag, input int k, input int id,
                               input int at);
        check_eq({tag, "_present"}, 32'(ev_id.size() > k), 1);
        if (ev_id.size() > k) begin
            check_eq({tag, "_id"}, 32'(ev_id[k]), 32'(id));
            check_eq({tag, "_cycle"}, 32'(ev_cyc[k]), 32'(at));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int a1;
        int n;

        // Single row miss: release 11 cycles after the accept cycle.
        do_reset();
        a0 = cyc;
        send(32'h0000_0400, 4'd3);
        log_releases(20);
        check_eq("miss_count", 32'(ev_id.size()), 1);
        check_event("miss", 0, 3, a0 + 11);

        // Row hit after a miss to the same row.
        do_reset();
        a0 = cyc;
        send(32'h0000_0400, 4'd1);
        a1 = cyc;
        send(32'h0000_0404, 4'd2);
        log_releases(20);
        check_eq("hit_count", 32'(ev_id.size()), 2);
`ifdef SIMMEM_ROW_HIT_EN
        check_event("hit_first", 0, 2, a1 + 3);
        check_event("hit_second", 1, 1, a0 + 11);
`else
        check_event("nohit_first", 0, 1, a0 + 11);
        check_event("nohit_second", 1, 2, a1 + 11);
`endif

        // Same ID: the younger entry waits for the older one.
        do_reset();
        a0 = cyc;
        send(32'h0000_0400, 4'd5);
        send(32'h0000_0404, 4'd5);
        log_releases(20);
        check_eq("order_count", 32'(ev_id.size()), 2);
        check_event("order_first", 0, 5, a0 + 11);
        check_event("order_second", 1, 5, a0 + 12);

        // Fill all slots under backpressure, then free exactly one.
        do_reset();
        release_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(32'(i) << 10, 4'(i));
        end
        check_eq("full_ready", 32'(addr_ready_o), 0);
        addr_i       = 32'h0000_2000;
        id_i         = 4'd9;
        addr_valid_i = 1'b1;
        n = 0;
        while (!release_valid_o && n < 20) begin
            step();
            n++;
        end
        check_eq("full_rel_valid", 32'(release_valid_o), 1);
        check_eq("full_rel_id", 32'(release_id_o), 0);
        check_eq("full_stall_ready", 32'(addr_ready_o), 0);
        step();
        step();
        step();
        check_eq("bp_stable_valid", 32'(release_valid_o), 1);
        check_eq("bp_stable_id", 32'(release_id_o), 0);
        check_eq("bp_still_full", 32'(addr_ready_o), 0);
        addr_valid_i    = 1'b0;
        release_ready_i = 1'b1;
        #1;
        check_eq("pulse_same_cycle_ready", 32'(addr_ready_o), 0);
        step();
        release_ready_i = 1'b0;
        #1;
        check_eq("pulse_next_cycle_ready", 32'(addr_ready_o), 1);
        check_eq("pulse_next_id", 32'(release_id_o), 1);
        release_ready_i = 1'b1;
        ev_id.delete();
        ev_cyc.delete();
        log_releases(30);
        check_eq("drain_count", 32'(ev_id.size()), 7);
        check_event("drain_last", 6, 7, ev_cyc.size() > 6 ? ev_cyc[6] : -1);

        // Reset with transactions pending.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(32'h0000_0400 + 32'(i * 4), 4'(i));
        end
        rst_i = 1'b1;
        #1;
        check_eq("midrst_addr_ready", 32'(addr_ready_o), 0);
        check_eq("midrst_release_valid", 32'(release_valid_o), 0);
        check_eq("midrst_release_id", 32'(release_id_o), 0);
        step();
        rst_i = 1'b0;
        #1;
        check_eq("midrst_after_ready", 32'(addr_ready_o), 1);
        ev_id.delete();
        ev_cyc.delete();
        log_releases(30);
        check_eq("midrst_no_release", 32'(ev_id.size()), 0);
        a0 = cyc;
        send(32'h0000_0404, 4'd6);
        log_releases(20);
        check_eq("midrst_new_count", 32'(ev_id.size()), 1);
        check_event("midrst_new", 0, 6, a0 + 11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
